stack_driver: RTL and testbench

//   Command-side initiator for the push/pop LIFO stack interface. Accepts
//   one push/pop command at a time over a valid/ready channel and drives

---
 rtl/stack_driver.sv | 88 ++++++++
 tb/tb_stack_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_driver.sv
// stack_driver: valid/ready command front-end that sequences push/pop on a LIFO stack
module stack_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_wdata,
  input  logic [DATA_WIDTH-1:0] stk_rdata,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic [PTR_WIDTH:0]    level,
  output logic [7:0]            err_cnt,
  output logic                  sync_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
  localparam logic [PTR_WIDTH:0] MAX_LEVEL = {1'b0, {PTR_WIDTH{1'b1}}};
  state_t state;
  logic op;
  logic accept;
  logic bad;
  assign cmd_ready = rst && state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign bad = cmd_op ? stk_empty : stk_full;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      op        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_wdata <= '0;
      level     <= '0;
      err_cnt   <= '0;
      sync_err  <= 1'b0;
    end else begin
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      if (state == IDLE && stk_empty != (level == '0)) sync_err <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          op        <= cmd_op;
          stk_wdata <= cmd_data;
          rsp_data  <= '0;
          rsp_err   <= bad;
          if (bad) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            err_cnt   <= err_cnt + {7'd0, err_cnt != 8'hFF};
          end else begin
            state    <= ISSUE;
            stk_push <= !cmd_op;
            stk_pop  <= cmd_op;
          end
        end
        ISSUE: begin
          // read_data lands one cycle after the pop strobe, so pops detour through WAIT_RD
          state     <= op ? WAIT_RD : RESP;
          rsp_valid <= !op;
          if (!op && level != MAX_LEVEL) level <= level + 1'b1;
          if (op && level != '0) level <= level - 1'b1;
        end
        WAIT_RD: begin
          rsp_data  <= stk_rdata;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_driver.sv
// tb_stack_driver: drives stack_driver against a behavioural 3-deep stack with a response scoreboard
module tb_stack_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic       stk_full;
  logic       stk_empty;
  logic [2:0] level;
  logic [7:0] err_cnt;
  logic       sync_err;
  int n_chk = 0;
  int n_fail = 0;
  int m_err = 0;
  logic [7:0] ref_stk[$];
  logic [8:0] sb[$];
  logic [7:0] smem[4];
  logic [1:0] sp;

  always #5 clk = ~clk;

  stack_driver #(.DATA_WIDTH(8), .PTR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_full(stk_full), .stk_empty(stk_empty),
    .level(level), .err_cnt(err_cnt), .sync_err(sync_err)
  );

  // Stack with registered read_data; sharing the driver's reset
  always @(posedge clk) begin
    if (!rst) begin
      sp <= 2'd0;
      stk_rdata <= 8'h00;
    end else if (stk_push && sp != 2'd3) begin
      smem[sp] <= stk_wdata;
      sp <= sp + 2'd1;
    end else if (stk_pop && sp != 2'd0) begin
      stk_rdata <= smem[sp - 2'd1];
      sp <= sp - 2'd1;
    end
  end
  assign stk_full = sp == 2'd3;
  assign stk_empty = sp == 2'd0;

  task automatic do_cmd(input logic op, input logic [7:0] d, input int hold);
    int n, np, nq, exp_lat;
    logic exp_err;
    logic [7:0] exp_d;
    logic [8:0] e;
    exp_err = op ? (ref_stk.size() == 0) : (ref_stk.size() == 3);
    exp_d = 8'h00;
    if (exp_err) begin
      if (m_err != 255) m_err++;
    end else if (op) exp_d = ref_stk.pop_back();
    else ref_stk.push_back(d);
    exp_lat = exp_err ? 1 : (op ? 3 : 2);
    sb.push_back({exp_err, exp_d});
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = 8'($urandom);
    n = 1; np = 0; nq = 0;
    while (!rsp_valid && n < 10) begin
      if (stk_push) np++;
      if (stk_pop) nq++;
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n != exp_lat) begin n_fail++; $display("FAIL latency op=%0d: got %0d want %0d", op, n, exp_lat); end
    n_chk++;
    if (np != int'(!exp_err && !op) || nq != int'(!exp_err && op)) begin
      n_fail++; $display("FAIL strobes op=%0d: push %0d pop %0d want %0d %0d", op, np, nq, !exp_err && !op, !exp_err && op);
    end
    e = sb.pop_front();
    n_chk++;
    if ({rsp_err, rsp_data} !== e) begin n_fail++; $display("FAIL response op=%0d: got err=%b data=%h want err=%b data=%h", op, rsp_err, rsp_data, e[8], e[7:0]); end
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 1'b0;
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e || cmd_ready !== 1'b0 || stk_push !== 1'b0) begin
        n_fail++; $display("FAIL hold cycle %0d: valid=%b err=%b data=%h ready=%b push=%b want 1 %b %h 0 0", i, rsp_valid, rsp_err, rsp_data, cmd_ready, stk_push, e[8], e[7:0]);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL handshake: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); end
    n_chk++;
    if (level !== 3'(ref_stk.size()) || err_cnt !== 8'(m_err)) begin
      n_fail++; $display("FAIL counters: level=%0d err_cnt=%0d want %0d %0d", level, err_cnt, ref_stk.size(), m_err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop, sync_err} !== 6'b0 || rsp_data !== 8'h00 || stk_wdata !== 8'h00 || level !== 3'd0 || err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: ready=%b valid=%b err=%b push=%b pop=%b data=%h wdata=%h level=%0d err_cnt=%0d sync=%b want all 0", cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop, rsp_data, stk_wdata, level, err_cnt, sync_err);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready); end
    ref_stk.delete();
    sb.delete();
    m_err = 0;
  endtask

  task automatic test_push;
    do_cmd(1'b0, 8'hA5, 0);
    n_chk++;
    if (stk_wdata !== 8'hA5) begin n_fail++; $display("FAIL wdata_held: got %h want a5", stk_wdata); end
    do_cmd(1'b1, 8'h00, 0);
  endtask

  task automatic test_lifo;
    do_cmd(1'b0, 8'hA1, 0);
    do_cmd(1'b0, 8'hA2, 0);
    do_cmd(1'b0, 8'hA3, 0);
    repeat (3) do_cmd(1'b1, 8'h00, 0);
  endtask

  task automatic test_pop_empty;
    do_cmd(1'b1, 8'h5A, 0);
  endtask

  task automatic test_overflow;
    do_cmd(1'b0, 8'hB1, 0);
    do_cmd(1'b0, 8'hB2, 0);
    do_cmd(1'b0, 8'hB3, 0);
    do_cmd(1'b0, 8'hB4, 0);
  endtask

  task automatic test_hold;
    do_cmd(1'b1, 8'h00, 5);
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1'b1;
    cmd_op = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_chk++;
    if (stk_pop !== 1'b1) begin n_fail++; $display("FAIL mid_issue: stk_pop=%b want 1", stk_pop); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop, sync_err} !== 6'b0 || rsp_data !== 8'h00 || stk_wdata !== 8'h00 || level !== 3'd0 || err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset: ready=%b valid=%b err=%b push=%b pop=%b data=%h wdata=%h level=%0d err_cnt=%0d sync=%b want all 0", cmd_ready, rsp_valid, rsp_err, stk_push, stk_pop, rsp_data, stk_wdata, level, err_cnt, sync_err);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1 || level !== 3'd0 || sync_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: ready=%b level=%0d sync=%b want 1 0 0", cmd_ready, level, sync_err);
    end
    ref_stk.delete();
    sb.delete();
    m_err = 0;
    do_cmd(1'b0, 8'h3C, 0);
    do_cmd(1'b1, 8'h00, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) do_cmd(i % 3 == 2, 8'($urandom), 0);
  endtask

  task automatic test_err_sat;
    while (ref_stk.size() != 0) do_cmd(1'b1, 8'h00, 0);
    for (int i = 0; i < 258; i++) do_cmd(1'b1, 8'h00, 0);
    n_chk++;
    if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL err_sat: got %0d want 255", err_cnt); end
  endtask

  initial begin
    test_reset;
    test_push;
    test_lifo;
    test_pop_empty;
    test_overflow;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    test_err_sat;
    n_chk++;
    if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sync_err: got %b want 0", sync_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
